// File: rtl/keypress_message_sequencer.sv
// ============================================================================
// keypress_message_sequencer
//
// Feeds a byte-serial transmitter with one fixed ASCII message per key press:
// "KEYn" optionally followed by CR LF, where n is the key index '0'..'9'.
// Presses are latched in a PENDING register and served lowest index first.
// One byte is handed over per TX_SEND / TX_DONE handshake.
//
// Parameters
//   KEY_COUNT          number of key inputs (1..10)
//   NEWLINE_EN         1 = 6-byte message with CR LF, 0 = 4-byte message
//   TX_TIMEOUT_CYCLES  cycles allowed for TX_DONE before the message is
//                      abandoned (must be >= 2); TX_ERROR rises
//                      TX_TIMEOUT_CYCLES-1 cycles after the unanswered TX_SEND
//
// Ports
//   CLK          in   system clock, rising edge
//   RESET        in   asynchronous reset, active low
//   KEY_PRESSED  in   one-cycle press pulses, bit i = key i
//   TX_SEND      out  one-cycle byte request, TX_DATA valid with it
//   TX_DATA      out  byte to send, held until the matching TX_DONE
//   TX_DONE      in   one-cycle pulse, current byte fully transmitted
//   BUSY         out  a message is in progress
//   OVERRUN      out  sticky, a press hit a key that was already pending
//   TX_ERROR     out  sticky, a TX_DONE timeout occurred
// ============================================================================
module keypress_message_sequencer #(
    parameter int KEY_COUNT         = 4,
    parameter int NEWLINE_EN        = 1,
    parameter int TX_TIMEOUT_CYCLES = 100000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [KEY_COUNT-1:0] KEY_PRESSED,
    output logic                 TX_SEND,
    output logic [7:0]           TX_DATA,
    input  logic                 TX_DONE,
    output logic                 BUSY,
    output logic                 OVERRUN,
    output logic                 TX_ERROR
);

    localparam int IDX_W   = (KEY_COUNT > 1) ? $clog2(KEY_COUNT) : 1;
    localparam int TIMER_W = (TX_TIMEOUT_CYCLES > 1) ? $clog2(TX_TIMEOUT_CYCLES) : 1;

    localparam logic [2:0] LAST_BYTE = (NEWLINE_EN != 0) ? 3'd5 : 3'd3;
    // The abort fires at the edge where the timer would reach
    // TX_TIMEOUT_CYCLES-1, so the compare value is one below that.
    localparam logic [TIMER_W-1:0] TIMER_ABORT = TIMER_W'(TX_TIMEOUT_CYCLES - 2);
    localparam logic [TIMER_W-1:0] TIMER_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t               state;
    logic [KEY_COUNT-1:0] pending;
    logic [IDX_W-1:0]     key_idx;
    logic [2:0]           byte_idx;
    logic [TIMER_W-1:0]   timer;

    logic [KEY_COUNT-1:0] lowest_onehot;
    logic [KEY_COUNT-1:0] clear_mask;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_valid;

    // Message byte table; the digit is formed from the captured key index.
    function automatic logic [7:0] msg_byte(input logic [2:0] idx,
                                            input logic [IDX_W-1:0] key);
        case (idx)
            3'd0:    msg_byte = 8'h4B;
            3'd1:    msg_byte = 8'h45;
            3'd2:    msg_byte = 8'h59;
            3'd3:    msg_byte = 8'h30 + 8'(key);
            3'd4:    msg_byte = 8'h0D;
            3'd5:    msg_byte = 8'h0A;
            default: msg_byte = 8'h00;
        endcase
    endfunction

    // Lowest-index arbitration: isolate the lowest set bit and encode it.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sel_valid     = |pending;
        sel_idx       = '0;
        lowest_onehot = pending & (~pending + 1'b1);
        for (int i = KEY_COUNT - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
        clear_mask = (state == S_IDLE) ? lowest_onehot : '0;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        // NOTE: the pending register and index/timer are plain flops, not a
        // memory, so they are all cleared by reset along with the outputs.
        if (!RESET) begin
            state    <= S_IDLE;
            pending  <= '0;
            key_idx  <= '0;
            byte_idx <= '0;
            timer    <= '0;
            TX_SEND  <= 1'b0;
            TX_DATA  <= 8'h00;
            BUSY     <= 1'b0;
            OVERRUN  <= 1'b0;
            TX_ERROR <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // reads the pre-edge values of state, pending and timer.
            // A press on the same edge as its clear wins, keeping the bit set.
            pending <= (pending & ~clear_mask) | KEY_PRESSED;

            if (|(KEY_PRESSED & pending & ~clear_mask)) begin
                OVERRUN <= 1'b1;
            end

            TX_SEND <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (sel_valid) begin
                        key_idx  <= sel_idx;
                        byte_idx <= 3'd0;
                        BUSY     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    TX_SEND <= 1'b1;
                    TX_DATA <= msg_byte(3'd0, key_idx);
                    timer   <= '0;
                    state   <= S_WAIT;
                end

                S_WAIT: begin
                    if (TX_DONE) begin
                        if (byte_idx == LAST_BYTE) begin
                            BUSY  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            // Next byte goes out with no idle gap.
                            byte_idx <= byte_idx + 3'd1;
                            TX_SEND  <= 1'b1;
                            TX_DATA  <= msg_byte(byte_idx + 3'd1, key_idx);
                            timer    <= '0;
                        end
                    end else if (timer == TIMER_ABORT) begin
                        // Transmitter stalled: drop the rest of the message.
                        TX_ERROR <= 1'b1;
                        BUSY     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (timer != TIMER_MAX) begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypress_message_sequencer.sv
// ============================================================================
// tb_keypress_message_sequencer
//
// Directed bench for keypress_message_sequencer. Instance A uses CR LF and a
// 50-cycle TX_DONE timeout; instance B has no CR LF. Each instance has a
// transmitter model answering TX_SEND with TX_DONE 20 cycles later, and a
// scoreboard queue of expected bytes filled by the stimulus and drained as
// the DUT issues TX_SEND.
// ============================================================================
module tb_keypress_message_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_a, key_b;
    logic       done_a, done_b;
    logic       tx_send_a, tx_send_b;
    logic [7:0] tx_data_a, tx_data_b;
    logic       busy_a, busy_b, overrun_a, overrun_b, err_a, err_b;

    always #5 clk = ~clk;

    keypress_message_sequencer #(
        .KEY_COUNT(4), .NEWLINE_EN(1), .TX_TIMEOUT_CYCLES(50)
    ) dut_a (
        .CLK(clk), .RESET(rst_n), .KEY_PRESSED(key_a),
        .TX_SEND(tx_send_a), .TX_DATA(tx_data_a), .TX_DONE(done_a),
        .BUSY(busy_a), .OVERRUN(overrun_a), .TX_ERROR(err_a)
    );

    keypress_message_sequencer #(
        .KEY_COUNT(4), .NEWLINE_EN(0), .TX_TIMEOUT_CYCLES(100000)
    ) dut_b (
        .CLK(clk), .RESET(rst_n), .KEY_PRESSED(key_b),
        .TX_SEND(tx_send_b), .TX_DATA(tx_data_b), .TX_DONE(done_b),
        .BUSY(busy_b), .OVERRUN(overrun_b), .TX_ERROR(err_b)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push the first nbytes of the message for key k onto a scoreboard.
    task automatic push_msg(input bit to_b, input int k, input int nbytes);
        logic [7:0] m [6];
        m[0] = 8'h4B; m[1] = 8'h45; m[2] = 8'h59;
        m[3] = 8'(8'h30 + k); m[4] = 8'h0D; m[5] = 8'h0A;
        for (int i = 0; i < nbytes; i++) begin
            if (to_b) q_b.push_back(m[i]);
            else      q_a.push_back(m[i]);
        end
    endtask

    // Transmitter models: TX_DONE 20 cycles after each TX_SEND. Model A
    // withholds TX_DONE for its send number withhold_at (0 = never).
    int cnt_a = 0, cnt_b = 0, sends_a = 0, withhold_at = 0;

    always @(negedge clk) begin
        done_a = 1'b0;
        if (!rst_n) begin
            cnt_a = 0;
        end else if (cnt_a > 0) begin
            cnt_a--;
            if (cnt_a == 0) done_a = 1'b1;
        end else if (tx_send_a) begin
            sends_a++;
            if (sends_a != withhold_at) cnt_a = 19;
        end
    end

    always @(negedge clk) begin
        done_b = 1'b0;
        if (!rst_n) begin
            cnt_b = 0;
        end else if (cnt_b > 0) begin
            cnt_b--;
            if (cnt_b == 0) done_b = 1'b1;
        end else if (tx_send_b) begin
            cnt_b = 19;
        end
    end

    // Scoreboards: every TX_SEND must match the next expected byte, and
    // TX_DATA must hold that byte for as long as the message is active.
    logic [7:0] last_a = 8'h00, last_b = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_a = 8'h00;
        end else if (tx_send_a) begin
            check("a_send_expected", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) check("a_byte", 32'(tx_data_a), 32'(q_a.pop_front()));
            last_a = tx_data_a;
        end else if (busy_a) begin
            check("a_data_held", 32'(tx_data_a), 32'(last_a));
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            last_b = 8'h00;
        end else if (tx_send_b) begin
            check("b_send_expected", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) check("b_byte", 32'(tx_data_b), 32'(q_b.pop_front()));
            last_b = tx_data_b;
        end else if (busy_b) begin
            check("b_data_held", 32'(tx_data_b), 32'(last_b));
        end
    end

    task automatic drain_a(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (q_a.size() == 0 && !busy_a) break;
        end
        check(tag, 32'(q_a.size() == 0 && !busy_a), 32'd1);
    endtask

    task automatic drain_b(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (q_b.size() == 0 && !busy_b) break;
        end
        check(tag, 32'(q_b.size() == 0 && !busy_b), 32'd1);
    endtask

    task automatic press_a(input logic [3:0] k);
        key_a = k;
        @(negedge clk);
        key_a = 4'b0000;
    endtask

    // Wait (bounded) for instance A to send a given byte.
    task automatic wait_send_a(input logic [7:0] b, input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (tx_send_a && tx_data_a == b) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        key_a = 4'b0000;
        key_b = 4'b0000;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_tx_send", 32'(tx_send_a), 32'd0);
        check("rst_tx_data", 32'(tx_data_a), 32'h00);
        check("rst_busy",    32'(busy_a),    32'd0);
        check("rst_overrun", 32'(overrun_a), 32'd0);
        check("rst_tx_error", 32'(err_a),    32'd0);
        check("rst_b_busy",  32'(busy_b),    32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- single press, latency ----------------
        push_msg(0, 2, 6);
        key_a = 4'b0100;
        @(negedge clk);                    // after sampling edge N
        key_a = 4'b0000;
        check("lat_n0_send", 32'(tx_send_a), 32'd0);
        check("lat_n0_busy", 32'(busy_a),    32'd0);
        @(negedge clk);                    // after N+1: LOAD
        check("lat_n1_send", 32'(tx_send_a), 32'd0);
        check("lat_n1_busy", 32'(busy_a),    32'd1);
        @(negedge clk);                    // after N+2: first TX_SEND
        check("lat_n2_send", 32'(tx_send_a), 32'd1);
        check("lat_n2_data", 32'(tx_data_a), 32'h4B);
        drain_a(1000, "single_drain");
        check("single_last_data", 32'(tx_data_a), 32'h0A);
        repeat (100) @(negedge clk);
        check("single_no_extra", 32'(q_a.size()), 32'd0);

        // ---------------- simultaneous and queued presses ----------------
        push_msg(0, 0, 6);
        push_msg(0, 2, 6);
        push_msg(0, 3, 6);
        press_a(4'b1001);
        repeat (40) @(negedge clk);
        press_a(4'b0100);
        drain_a(3000, "queued_drain");
        check("queued_overrun", 32'(overrun_a), 32'd0);

        // ---------------- overrun ----------------
        push_msg(0, 0, 6);
        push_msg(0, 1, 6);
        press_a(4'b0001);
        repeat (30) @(negedge clk);
        press_a(4'b0010);
        check("ovr_first_press", 32'(overrun_a), 32'd0);
        repeat (30) @(negedge clk);
        press_a(4'b0010);
        check("ovr_set", 32'(overrun_a), 32'd1);
        drain_a(2000, "ovr_drain");
        check("ovr_sticky", 32'(overrun_a), 32'd1);

        // ---------------- TX_DONE timeout ----------------
        sends_a     = 0;
        withhold_at = 3;
        push_msg(0, 1, 3);
        press_a(4'b0010);
        wait_send_a(8'h59, 300, "tmo_third_send");
        repeat (48) @(negedge clk);
        check("tmo_err_before", 32'(err_a),  32'd0);
        check("tmo_busy_before", 32'(busy_a), 32'd1);
        @(negedge clk);
        check("tmo_err_at_49", 32'(err_a),  32'd1);
        check("tmo_idle",      32'(busy_a), 32'd0);
        withhold_at = 0;
        push_msg(0, 3, 6);
        press_a(4'b1000);
        drain_a(1000, "tmo_recover_drain");
        check("tmo_err_sticky", 32'(err_a), 32'd1);

        // ---------------- NEWLINE_EN = 0 ----------------
        push_msg(1, 3, 4);
        key_b = 4'b1000;
        @(negedge clk);
        key_b = 4'b0000;
        drain_b(1000, "nonl_drain");
        check("nonl_last_data", 32'(tx_data_b), 32'h33);
        repeat (100) @(negedge clk);
        check("nonl_no_extra", 32'(q_b.size()), 32'd0);

        // ---------------- reset mid-message ----------------
        push_msg(0, 1, 2);
        press_a(4'b0010);
        wait_send_a(8'h45, 300, "rstmid_second_send");
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_send",    32'(tx_send_a), 32'd0);
        check("rstmid_data",    32'(tx_data_a), 32'h00);
        check("rstmid_busy",    32'(busy_a),    32'd0);
        check("rstmid_overrun", 32'(overrun_a), 32'd0);
        check("rstmid_error",   32'(err_a),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        check("rstmid_quiet_busy", 32'(busy_a), 32'd0);
        check("rstmid_queue", 32'(q_a.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
